max_pool_stream: RTL and testbench

Streaming, multi-channel max-pool layer with an integrated backward (gradient-routing) pass, for use between convolution stages in the CNN datapath. Forward mode consumes input pixels in raster order over a valid/ready stream and emits pooled pixels as each window completes, recording per-window argmax positions. Backward mode consumes output gradients one pooled row at a time and emits the full-resolution input gradient in raster order. Each gradient is routed to its recorded argmax position; all other positions in the window receive zero.

---
 rtl/max_pool_stream.sv | 178 +++++++++++++++++
 tb/tb_max_pool_stream.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_stream.sv
// rtl/max_pool_stream.sv - streaming multi-channel max-pool with argmax-routed backward pass
module max_pool_stream #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int POOL     = 2,
  parameter int IN_W     = 8,
  parameter int IN_H     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         mode,
  output logic                         busy,
  output logic                         done,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*WIDTH-1:0]    out_data
);
  localparam int OUT_W = IN_W / POOL;
  localparam int OUT_H = IN_H / POOL;
  localparam int IW    = $clog2(POOL * POOL);
  localparam int PW    = $clog2(POOL);
  localparam int XW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int YW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int AW    = (OUT_W * OUT_H > 1) ? $clog2(OUT_W * OUT_H) : 1;

  typedef enum logic [1:0] {IDLE, FWD, BWD_LOAD, BWD_EMIT} state_t;
  state_t state, state_nx;

  // Raster position as (pooled row, row-in-window, pooled col, col-in-window); shared by both modes
  logic [PW-1:0] wc, wr;
  logic [XW-1:0] pc, lcnt;
  logic [YW-1:0] pr;
  logic          fwd_valid, fwd_final, done_nx;
  logic [CHANNELS*WIDTH-1:0] fwd_data, cand_data, bwd_data;

  logic signed [WIDTH-1:0] row_val [OUT_W][CHANNELS];
  logic [IW-1:0]           row_idx [OUT_W][CHANNELS];
  logic [WIDTH-1:0]        grad    [OUT_W][CHANNELS];
  logic [IW-1:0]           amem    [OUT_W*OUT_H][CHANNELS];

  logic signed [WIDTH-1:0] cand_val [CHANNELS];
  logic [IW-1:0]           cand_idx [CHANNELS];
  logic [IW-1:0]           offset;
  logic [AW-1:0]           addr;
  logic in_fire, out_fire, step, win_first, win_last, row_last, frame_last;

  assign offset     = IW'(int'(wr) * POOL + int'(wc));
  assign addr       = AW'(int'(pr) * OUT_W + int'(pc));
  assign win_first  = (wr == '0) && (wc == '0);
  assign win_last   = (wr == PW'(POOL - 1)) && (wc == PW'(POOL - 1));
  assign row_last   = win_last && (pc == XW'(OUT_W - 1));
  assign frame_last = row_last && (pr == YW'(OUT_H - 1));

  assign busy      = (state != IDLE);
  assign out_valid = fwd_valid || (state == BWD_EMIT);
  assign out_data  = (state == BWD_EMIT) ? bwd_data : fwd_data;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign step      = ((state == FWD) && in_fire) || ((state == BWD_EMIT) && out_fire);

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      cand_val[c] = $signed(in_data[c*WIDTH +: WIDTH]);
      cand_idx[c] = offset;
      if (!win_first && !(cand_val[c] > row_val[pc][c])) begin
        cand_val[c] = row_val[pc][c];
        cand_idx[c] = row_idx[pc][c];
      end
      cand_data[c*WIDTH +: WIDTH] = cand_val[c];
      bwd_data[c*WIDTH +: WIDTH]  = (amem[addr][c] == offset) ? grad[pc][c] : '0;
    end
  end

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    in_ready = 1'b0;
    case (state)
      IDLE: if (start) state_nx = mode ? BWD_LOAD : FWD;
      FWD: begin
        // Stop taking pixels once the frame is in; only the last result remains to drain
        in_ready = (!fwd_valid || out_ready) && !fwd_final;
        if (fwd_final && fwd_valid && out_ready) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      BWD_LOAD: begin
        in_ready = 1'b1;
        if (in_fire && lcnt == XW'(OUT_W - 1)) state_nx = BWD_EMIT;
      end
      BWD_EMIT: begin
        if (out_fire && row_last) begin
          if (pr == YW'(OUT_H - 1)) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx = BWD_LOAD;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wc <= '0; wr <= '0; pc <= '0; pr <= '0; lcnt <= '0;
      fwd_valid <= 1'b0;
      fwd_final <= 1'b0;
      fwd_data  <= '0;
      for (int i = 0; i < OUT_W; i++) begin
        for (int c = 0; c < CHANNELS; c++) begin
          row_val[i][c] <= '0;
          row_idx[i][c] <= '0;
          grad[i][c]    <= '0;
        end
      end
      for (int a = 0; a < OUT_W * OUT_H; a++) begin
        for (int c = 0; c < CHANNELS; c++) amem[a][c] <= '0;
      end
    end else begin
      if (state == IDLE && start) begin
        wc <= '0; wr <= '0; pc <= '0; pr <= '0; lcnt <= '0;
        fwd_final <= 1'b0;
      end
      if (out_ready) fwd_valid <= 1'b0;
      if (state == FWD && in_fire) begin
        for (int c = 0; c < CHANNELS; c++) begin
          row_val[pc][c] <= cand_val[c];
          row_idx[pc][c] <= cand_idx[c];
        end
        if (win_last) begin
          fwd_valid <= 1'b1;
          fwd_data  <= cand_data;
          for (int c = 0; c < CHANNELS; c++) amem[addr][c] <= cand_idx[c];
        end
        if (frame_last) fwd_final <= 1'b1;
      end
      if (state == BWD_LOAD && in_fire) begin
        for (int c = 0; c < CHANNELS; c++) grad[lcnt][c] <= in_data[c*WIDTH +: WIDTH];
        lcnt <= (lcnt == XW'(OUT_W - 1)) ? '0 : lcnt + 1'b1;
      end
      if (step) begin
        if (wc == PW'(POOL - 1)) begin
          wc <= '0;
          if (pc == XW'(OUT_W - 1)) begin
            pc <= '0;
            if (wr == PW'(POOL - 1)) begin
              wr <= '0;
              pr <= (pr == YW'(OUT_H - 1)) ? '0 : pr + 1'b1;
            end else begin
              wr <= wr + 1'b1;
            end
          end else begin
            pc <= pc + 1'b1;
          end
        end else begin
          wc <= wc + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_max_pool_stream.sv
// tb/tb_max_pool_stream.sv - directed bench for max_pool_stream on a 4x4x4 map with 2x2 pooling
module tb_max_pool_stream;
  logic        clk, rst_n, start, mode, busy, done;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data;

  int n_checks = 0;
  int n_err = 0;

  int pix      [16][4];
  int exp_out  [4][4];
  int exp_idx  [4][4];
  int grads    [4][4];

  max_pool_stream #(.WIDTH(16), .CHANNELS(4), .POOL(2), .IN_W(4), .IN_H(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pos(input int w, input int off);
    return ((w / 2) * 2 + off / 2) * 4 + (w % 2) * 2 + off % 2;
  endfunction

  function automatic bit is_last(input int b);
    return ((b / 4) % 2 == 1) && ((b % 4) % 2 == 1);
  endfunction

  task automatic set_win(input int w, input int c, input int a0, input int a1, input int a2, input int a3);
    pix[pos(w, 0)][c] = a0;
    pix[pos(w, 1)][c] = a1;
    pix[pos(w, 2)][c] = a2;
    pix[pos(w, 3)][c] = a3;
  endtask

  task automatic fwd_pass(input int rdy_pct);
    int beat, outs, cyc;
    bit exp_ov, ifire, ofire, stall;
    logic [63:0] held;
    @(negedge clk); start = 1'b1; mode = 1'b0;
    @(negedge clk); start = 1'b0;
    beat = 0; outs = 0; cyc = 0; exp_ov = 1'b0; stall = 1'b0; held = '0;
    while (outs < 4 && cyc < 400) begin
      in_valid = (beat < 16);
      for (int c = 0; c < 4; c++) in_data[c*16 +: 16] = (beat < 16) ? 16'(pix[beat][c]) : 16'h0;
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      #1;
      check("fwd_busy", busy, 1);
      check("fwd_out_valid", out_valid, exp_ov);
      if (beat < 16) check("fwd_in_ready", in_ready, !exp_ov || out_ready);
      if (stall)
        for (int c = 0; c < 4; c++) check("fwd_stall_stable", $signed(out_data[c*16 +: 16]), $signed(held[c*16 +: 16]));
      ifire = in_valid && (!exp_ov || out_ready);
      ofire = exp_ov && out_ready;
      if (ofire)
        for (int c = 0; c < 4; c++)
          check($sformatf("fwd_out%0d_ch%0d", outs, c), $signed(out_data[c*16 +: 16]), exp_out[outs][c]);
      stall = exp_ov && !out_ready;
      held = out_data;
      if (ofire) begin outs++; exp_ov = 1'b0; end
      if (ifire) begin
        if (is_last(beat)) exp_ov = 1'b1;
        beat++;
      end
      @(negedge clk);
      cyc++;
    end
    if (outs < 4) check("fwd_timeout", outs, 4);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("fwd_done", done, 1);
    check("fwd_busy_end", busy, 0);
    @(negedge clk); #1;
    check("fwd_done_pulse", done, 0);
  endtask

  task automatic bwd_pass(input int rdy_pct);
    int r, lc, e, cyc, y, x, w, off;
    bit emit, stall, ofire;
    logic [63:0] held;
    @(negedge clk); start = 1'b1; mode = 1'b1;
    @(negedge clk); start = 1'b0;
    r = 0; lc = 0; e = 0; cyc = 0; emit = 1'b0; stall = 1'b0; held = '0;
    while (r < 2 && cyc < 400) begin
      in_valid = !emit;
      for (int c = 0; c < 4; c++) in_data[c*16 +: 16] = emit ? 16'h0 : 16'(grads[r*2 + lc][c]);
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      #1;
      check("bwd_in_ready", in_ready, !emit);
      check("bwd_out_valid", out_valid, emit);
      if (stall)
        for (int c = 0; c < 4; c++) check("bwd_stall_stable", $signed(out_data[c*16 +: 16]), $signed(held[c*16 +: 16]));
      ofire = emit && out_ready;
      if (ofire) begin
        y = e / 4; x = e % 4; w = r * 2 + x / 2; off = y * 2 + x % 2;
        for (int c = 0; c < 4; c++)
          check($sformatf("bwd_r%0d_y%0d_x%0d_ch%0d", r, y, x, c), $signed(out_data[c*16 +: 16]),
                (exp_idx[w][c] == off) ? grads[w][c] : 0);
      end
      stall = emit && !out_ready;
      held = out_data;
      if (!emit) begin
        lc++;
        if (lc == 2) begin emit = 1'b1; e = 0; end
      end else if (ofire) begin
        e++;
        if (e == 8) begin emit = 1'b0; lc = 0; r++; end
      end
      @(negedge clk);
      cyc++;
    end
    if (r < 2) check("bwd_timeout", r, 2);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("bwd_done", done, 1);
    check("bwd_busy_end", busy, 0);
    @(negedge clk); #1;
    check("bwd_done_pulse", done, 0);
  endtask

  task automatic rand_fill();
    int best, bi, v;
    for (int b = 0; b < 16; b++) begin
      pix[b][0] = int'($urandom_range(0, 65535)) - 32768;
      pix[b][1] = int'($urandom_range(0, 6)) - 3;
      pix[b][2] = -1 - int'($urandom_range(0, 40));
      pix[b][3] = int'($urandom_range(0, 1));
    end
    for (int w = 0; w < 4; w++) begin
      for (int c = 0; c < 4; c++) begin
        best = 0; bi = 0;
        for (int off = 0; off < 4; off++) begin
          v = pix[pos(w, off)][c];
          if (off == 0 || v > best) begin best = v; bi = off; end
        end
        exp_out[w][c] = best;
        exp_idx[w][c] = bi;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", int'(out_data[31:0] | out_data[63:32]), 0);
    rst_n = 1'b1;

    // Forward reference frame: ch1 negated, ch2 rising, ch3 falling
    set_win(0, 0, 1, 5, 3, 4);
    set_win(1, 0, 2, 0, 8, 7);
    set_win(2, 0, -1, -2, -3, -4);
    set_win(3, 0, 6, 6, 6, 9);
    for (int b = 0; b < 16; b++) begin
      pix[b][1] = -pix[b][0];
      pix[b][2] = 100 + b;
      pix[b][3] = -1 - b;
    end
    exp_out[0] = '{5, -1, 105, -1};   exp_idx[0] = '{1, 0, 3, 0};
    exp_out[1] = '{8, 0, 107, -3};    exp_idx[1] = '{2, 1, 3, 0};
    exp_out[2] = '{-1, 4, 113, -9};   exp_idx[2] = '{0, 3, 3, 0};
    exp_out[3] = '{9, -6, 115, -11};  exp_idx[3] = '{3, 0, 3, 0};
    fwd_pass(100);

    grads[0] = '{10, 1, 500, -7};
    grads[1] = '{-20, -2, 600, 7};
    grads[2] = '{30, 3, 700, -7};
    grads[3] = '{-40, -4, 800, 7};
    bwd_pass(100);

    // Ties, negatives and extremes under backpressure
    set_win(0, 0, 7, 7, 7, 7);
    set_win(1, 0, -9, -3, -3, -5);
    set_win(2, 0, 0, 0, 0, 1);
    set_win(3, 0, -1, -1, -1, -1);
    for (int w = 0; w < 4; w++) set_win(w, 1, 0, 0, 0, 0);
    set_win(0, 2, -32768, -32768, -32768, 32767);
    set_win(1, 2, 32767, -32768, 32767, 32767);
    set_win(2, 2, -32768, -32768, -32768, -32768);
    set_win(3, 2, -32768, -32767, -32768, -32768);
    for (int w = 0; w < 4; w++)
      for (int off = 0; off < 4; off++) pix[pos(w, off)][3] = (off == w) ? 2 : 1;
    exp_out[0] = '{7, 0, 32767, 2};    exp_idx[0] = '{0, 0, 3, 0};
    exp_out[1] = '{-3, 0, 32767, 2};   exp_idx[1] = '{1, 0, 0, 1};
    exp_out[2] = '{1, 0, -32768, 2};   exp_idx[2] = '{3, 0, 0, 2};
    exp_out[3] = '{-1, 0, -32767, 2};  exp_idx[3] = '{0, 0, 1, 3};
    fwd_pass(30);
    for (int w = 0; w < 4; w++) grads[w] = '{11, 11, 11, 11};
    bwd_pass(30);

    // 64 random windows across 16 frames, then a random-gradient backward pass
    for (int p = 0; p < 16; p++) begin
      rand_fill();
      fwd_pass((p % 2 == 1) ? 30 : 100);
    end
    for (int w = 0; w < 4; w++)
      for (int c = 0; c < 4; c++) grads[w][c] = int'($urandom_range(0, 65535)) - 32768;
    bwd_pass(30);

    // Reset while emitting, then argmax memory must read back as offset 0
    @(negedge clk); start = 1'b1; mode = 1'b1;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 64'h0005_0004_0003_0002;
    @(negedge clk);
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("mid_emit_valid", out_valid, 1);
    check("mid_emit_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_data", int'(out_data[31:0] | out_data[63:32]), 0);
    repeat (2) begin
      @(negedge clk); #1;
      check("mid_rst_no_done", done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("post_rst_no_done", done, 0);
    check("post_rst_busy", busy, 0);
    for (int w = 0; w < 4; w++) begin
      exp_idx[w] = '{0, 0, 0, 0};
      for (int c = 0; c < 4; c++) grads[w][c] = (w + 1) * 10 * (c % 2 == 0 ? 1 : -1) + c;
    end
    bwd_pass(100);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
